logsin_arb: RTL and testbench
=============================

LOGSIN_ARB -- requirements
Module: logsin_arb

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port req_valid, input, 4, per-requester lookup request; requester i holds bit i and its operands stable until granted.
REQ-004 SHALL have port req_phase, input, 4x10 (40, requester i at [10i+9:10i]), phase word: [9] sign, [8] mirror, [7:0] index.
REQ-005 SHALL have port req_atten, input, 4x10 (40, same packing), attenuation in envelope units.
REQ-006 SHALL have port req_ready, output, 4, one-hot grant pulse; high for one cycle on the cycle requester i is accepted.
REQ-007 SHALL have port lut_idx, output, 8, index driven to the external log-sin table.
REQ-008 SHALL have port lut_value, input, 12, combinational table result for lut_idx.
REQ-009 SHALL have port rsp_valid, output, 1, result strobe, one cycle per accepted request.
REQ-010 SHALL have port rsp_id, output, 2, requester number of the result.
REQ-011 SHALL have port rsp_logsin, output, 12, attenuated log-sin magnitude.
REQ-012 SHALL have port rsp_sign, output, 1, copy of phase[9] of the request.

Function
REQ-013 SHALL accept at most one request per cycle; a request is accepted in the cycle req_ready[i]=1, which SHALL only occur while req_valid[i]=1.
REQ-014 SHALL arbitrate round-robin: search starts at requester (last_grant+1) mod 4, wrapping 3->0; last_grant updates only on an accepting cycle.
REQ-015 SHALL grant in the same cycle a request is valid if the pipeline is free (no backpressure exists; pipeline is always free), so a lone requester is accepted every cycle.
REQ-016 SHALL, at acceptance (stage 0), register lut_idx = phase[8] ? ~phase[7:0] : phase[7:0], plus id, sign and atten into a stage-1 register with valid bit.
REQ-017 SHALL, in stage 1, compute sum = lut_value + {atten,2'b00} at 13 bits and register rsp_logsin = sum>0xFFF ? 0xFFF : sum[11:0].
REQ-018 SHALL assert rsp_valid exactly 2 cycles after the accepting edge (accept at edge N, rsp_valid high after edge N+2), with rsp_id/rsp_sign of that request.
REQ-019 SHALL sustain one result per cycle with back-to-back grants; rsp outputs are held between strobes.
REQ-020 SHALL treat req_valid deasserting without grant as a withdrawn request (no response, no state change).
REQ-021 SHALL produce no req_ready and no rsp_valid when req_valid=0.

Reset
REQ-022 SHALL on reset assert: req_ready=0, rsp_valid=0, rsp_id=0, rsp_logsin=0, rsp_sign=0, lut_idx=0, all pipeline valid bits=0, last_grant=3 (so requester 0 wins first).
REQ-023 SHALL discard any in-flight request when reset asserts mid-pipeline; no rsp_valid for it after reset release.
REQ-024 SHALL first grant on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL honour macro LOGSIN_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority (requester 0 highest, 3 lowest) and last_grant is not implemented; when undefined, round-robin per REQ-014.

Verification
REQ-026 Requester 0 only, phase 0x000, atten 0 -> lut_idx 0x00, rsp_logsin 0x859, sign 0, id 0, two cycles after grant.
REQ-027 Requester 2, phase 0x300, atten 0 -> lut_idx 0xFF, rsp_logsin 0x000, rsp_sign 1, id 2.
REQ-028 Requester 1, phase 0x000, atten 0x3FF -> 0x859+0xFFC saturates, rsp_logsin 0xFFF.
REQ-029 All four valid continuously -> grants 0,1,2,3,0,... one per cycle, rsp_id in same order, 4 results in 4 consecutive cycles (with macro: requester 0 granted every cycle).
REQ-030 Requester 3 accepted, reset pulsed one cycle later -> no rsp_valid after release; next grant goes to requester 0.

Source files
------------

// File: rtl/logsin_arb.sv
// Four-requester round-robin front end for an external log-sin table, with a fixed
// two-cycle result latency. Define LOGSIN_ARB_FIXED_PRIO_EN for fixed priority (0 highest).
module logsin_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [39:0] req_phase,
    input  logic [39:0] req_atten,
    output logic [3:0]  req_ready,
    output logic [7:0]  lut_idx,
    input  logic [11:0] lut_value,
    output logic        rsp_valid,
    output logic [1:0]  rsp_id,
    output logic [11:0] rsp_logsin,
    output logic        rsp_sign
);

    function automatic logic [11:0] sat12(input logic [12:0] sum);
        return sum[12] ? 12'hFFF : sum[11:0];
    endfunction

    logic [9:0]  phase_a [4];
    logic [9:0]  atten_a [4];
    logic [3:0]  grant_s;
    logic [1:0]  grant_id_s;
    logic        accept_s;
    logic        hit_s;
    logic [1:0]  cand_s;
    logic [9:0]  sel_phase_s;
    logic [9:0]  sel_atten_s;

`ifndef LOGSIN_ARB_FIXED_PRIO_EN
    logic [1:0]  last_grant_q, last_grant_d;
`endif
    logic [7:0]  lut_idx_q, lut_idx_d;
    logic        s1_valid_q, s1_valid_d;
    logic [1:0]  s1_id_q, s1_id_d;
    logic        s1_sign_q, s1_sign_d;
    logic [9:0]  s1_atten_q, s1_atten_d;
    logic        s2_valid_q, s2_valid_d;
    logic [1:0]  s2_id_q, s2_id_d;
    logic        s2_sign_q, s2_sign_d;
    logic [12:0] s2_sum_q, s2_sum_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [1:0]  rsp_id_q, rsp_id_d;
    logic [11:0] rsp_logsin_q, rsp_logsin_d;
    logic        rsp_sign_q, rsp_sign_d;

    // Unpack the flat requester buses
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            phase_a[i] = req_phase[10*i +: 10];
            atten_a[i] = req_atten[10*i +: 10];
        end
    end

    // Arbiter: the pipeline never stalls, so any valid requester can be granted this cycle
    always_comb begin
        grant_s    = 4'b0000;
        grant_id_s = 2'd0;
        accept_s   = 1'b0;
        hit_s      = 1'b0;
        cand_s     = 2'd0;
        for (int k = 0; k < 4; k++) begin
`ifdef LOGSIN_ARB_FIXED_PRIO_EN
            cand_s     = 2'(k);
`else
            cand_s     = last_grant_q + 2'd1 + 2'(k);
`endif
            hit_s      = ~reset & ~accept_s & req_valid[cand_s];
            grant_id_s = hit_s ? cand_s : grant_id_s;
            grant_s    = grant_s | ({3'b000, hit_s} << cand_s);
            accept_s   = accept_s | hit_s;
        end
    end

    assign sel_phase_s = phase_a[grant_id_s];
    assign sel_atten_s = atten_a[grant_id_s];

    // Pipeline next state: accept -> table lookup -> add -> saturated result
    always_comb begin
`ifndef LOGSIN_ARB_FIXED_PRIO_EN
        last_grant_d = accept_s ? grant_id_s : last_grant_q;
`endif
        lut_idx_d    = lut_idx_q;
        s1_valid_d   = accept_s;
        s1_id_d      = s1_id_q;
        s1_sign_d    = s1_sign_q;
        s1_atten_d   = s1_atten_q;
        s2_valid_d   = s1_valid_q;
        s2_id_d      = s2_id_q;
        s2_sign_d    = s2_sign_q;
        s2_sum_d     = s2_sum_q;
        rsp_valid_d  = s2_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sign_d   = rsp_sign_q;
        rsp_logsin_d = rsp_logsin_q;

        if (accept_s) begin
            lut_idx_d  = sel_phase_s[8] ? ~sel_phase_s[7:0] : sel_phase_s[7:0];
            s1_id_d    = grant_id_s;
            s1_sign_d  = sel_phase_s[9];
            s1_atten_d = sel_atten_s;
        end else begin
            lut_idx_d  = lut_idx_q;
        end

        // lut_value is valid for the whole cycle after lut_idx is loaded
        if (s1_valid_q) begin
            s2_id_d   = s1_id_q;
            s2_sign_d = s1_sign_q;
            s2_sum_d  = {1'b0, lut_value} + {1'b0, s1_atten_q, 2'b00};
        end else begin
            s2_sum_d  = s2_sum_q;
        end

        // Result fields hold their last value between strobes
        if (s2_valid_q) begin
            rsp_id_d     = s2_id_q;
            rsp_sign_d   = s2_sign_q;
            rsp_logsin_d = sat12(s2_sum_q);
        end else begin
            rsp_logsin_d = rsp_logsin_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifndef LOGSIN_ARB_FIXED_PRIO_EN
            last_grant_q <= 2'd3;
`endif
            lut_idx_q    <= 8'h00;
            s1_valid_q   <= 1'b0;
            s1_id_q      <= 2'd0;
            s1_sign_q    <= 1'b0;
            s1_atten_q   <= 10'd0;
            s2_valid_q   <= 1'b0;
            s2_id_q      <= 2'd0;
            s2_sign_q    <= 1'b0;
            s2_sum_q     <= 13'd0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 2'd0;
            rsp_sign_q   <= 1'b0;
            rsp_logsin_q <= 12'h000;
        end else begin
`ifndef LOGSIN_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
            lut_idx_q    <= lut_idx_d;
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s1_sign_q    <= s1_sign_d;
            s1_atten_q   <= s1_atten_d;
            s2_valid_q   <= s2_valid_d;
            s2_id_q      <= s2_id_d;
            s2_sign_q    <= s2_sign_d;
            s2_sum_q     <= s2_sum_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sign_q   <= rsp_sign_d;
            rsp_logsin_q <= rsp_logsin_d;
        end
    end

    assign req_ready  = grant_s;
    assign lut_idx    = lut_idx_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_sign   = rsp_sign_q;
    assign rsp_logsin = rsp_logsin_q;

endmodule

// File: tb/tb_logsin_arb.sv
// Directed bench for logsin_arb: table of single-requester lookups plus
// hand-written sequences for arbitration order, withdrawal and mid-pipeline reset.
module tb_logsin_arb;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [39:0] req_phase;
    logic [39:0] req_atten;
    logic [3:0]  req_ready;
    logic [7:0]  lut_idx;
    logic [11:0] lut_value;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [11:0] rsp_logsin;
    logic        rsp_sign;

    int n_tests = 0;
    int n_fail  = 0;

    logsin_arb dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_phase  (req_phase),
        .req_atten  (req_atten),
        .req_ready  (req_ready),
        .lut_idx    (lut_idx),
        .lut_value  (lut_value),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_logsin (rsp_logsin),
        .rsp_sign   (rsp_sign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in table: entry 0 is 0x859, entry 0xFF is 0, others (~idx)*8
    function automatic logic [11:0] lut_fn(input logic [7:0] i);
        logic [7:0] n;
        n = ~i;
        if (i == 8'h00) return 12'h859;
        return {1'b0, n, 3'b000};
    endfunction

    always_comb lut_value = lut_fn(lut_idx);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  id;
        logic [9:0]  phase;
        logic [9:0]  atten;
        logic [7:0]  exp_idx;
        logic [11:0] exp_logsin;
        logic        exp_sign;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [1:0] rr_grant(input int k);
`ifdef LOGSIN_ARB_FIXED_PRIO_EN
        return 2'd0;
`else
        return 2'(k % 4);
`endif
    endfunction

    initial begin
        logic [3:0] er;
        int cnt;

        vecs[0] = '{id: 2'd0, phase: 10'h000, atten: 10'h000, exp_idx: 8'h00, exp_logsin: 12'h859, exp_sign: 1'b0};
        vecs[1] = '{id: 2'd2, phase: 10'h300, atten: 10'h000, exp_idx: 8'hFF, exp_logsin: 12'h000, exp_sign: 1'b1};
        vecs[2] = '{id: 2'd1, phase: 10'h000, atten: 10'h3FF, exp_idx: 8'h00, exp_logsin: 12'hFFF, exp_sign: 1'b0};
        vecs[3] = '{id: 2'd3, phase: 10'h105, atten: 10'h010, exp_idx: 8'hFA, exp_logsin: 12'h068, exp_sign: 1'b0};
        vecs[4] = '{id: 2'd0, phase: 10'h20A, atten: 10'h001, exp_idx: 8'h0A, exp_logsin: 12'h7AC, exp_sign: 1'b1};
        vecs[5] = '{id: 2'd1, phase: 10'h0FF, atten: 10'h3FF, exp_idx: 8'hFF, exp_logsin: 12'hFFC, exp_sign: 1'b0};
        vecs[6] = '{id: 2'd2, phase: 10'h1FF, atten: 10'h200, exp_idx: 8'h00, exp_logsin: 12'hFFF, exp_sign: 1'b0};

        // Reset state, with requests present to show no grant while in reset
        reset     = 1'b1;
        req_valid = 4'hF;
        req_phase = 40'd0;
        req_atten = 40'd0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_id", 32'(rsp_id), 32'h0);
        chk("reset_rsp_logsin", 32'(rsp_logsin), 32'h0);
        chk("reset_rsp_sign", 32'(rsp_sign), 32'h0);
        chk("reset_lut_idx", 32'(lut_idx), 32'h0);
        req_valid = 4'h0;
        after_edge();
        reset = 1'b0;

        // Single-requester lookups
        for (int v = 0; v < 7; v++) begin
            er = 4'b0001 << vecs[v].id;
            req_phase = 40'd0;
            req_atten = 40'd0;
            req_phase[int'(vecs[v].id)*10 +: 10] = vecs[v].phase;
            req_atten[int'(vecs[v].id)*10 +: 10] = vecs[v].atten;
            req_valid = er;
            @(negedge clk);
            chk($sformatf("v%0d_ready", v), 32'(req_ready), 32'(er));
            after_edge();
            req_valid = 4'h0;
            chk($sformatf("v%0d_lut_idx", v), 32'(lut_idx), 32'(vecs[v].exp_idx));
            @(negedge clk);
            chk($sformatf("v%0d_early0", v), 32'(rsp_valid), 32'h0);
            @(negedge clk);
            chk($sformatf("v%0d_early1", v), 32'(rsp_valid), 32'h0);
            @(negedge clk);
            chk($sformatf("v%0d_rsp_valid", v), 32'(rsp_valid), 32'h1);
            chk($sformatf("v%0d_rsp_id", v), 32'(rsp_id), 32'(vecs[v].id));
            chk($sformatf("v%0d_rsp_logsin", v), 32'(rsp_logsin), 32'(vecs[v].exp_logsin));
            chk($sformatf("v%0d_rsp_sign", v), 32'(rsp_sign), 32'(vecs[v].exp_sign));
            @(negedge clk);
            chk($sformatf("v%0d_strobe_end", v), 32'(rsp_valid), 32'h0);
            chk($sformatf("v%0d_hold", v), 32'(rsp_logsin), 32'(vecs[v].exp_logsin));
            after_edge();
        end

        // Requester 3 accepted, then reset one cycle later kills it in flight
        req_phase = 40'd0;
        req_atten = 40'd0;
        req_valid = 4'b1000;
        @(negedge clk);
        chk("inflight_ready", 32'(req_ready), 32'h8);
        after_edge();
        req_valid = 4'h0;
        after_edge();
        reset = 1'b1;
        after_edge();
        reset = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("inflight_discarded", 32'(cnt), 32'h0);
        after_edge();

        // All four requesting continuously; requester i looks up index i
        for (int i = 0; i < 4; i++) req_phase[10*i +: 10] = 10'(i);
        for (int k = 0; k < 11; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            @(negedge clk);
            er = (k < 8) ? (4'b0001 << rr_grant(k)) : 4'b0000;
            chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(er));
            if (k >= 3) begin
                chk($sformatf("rr%0d_rsp_valid", k), 32'(rsp_valid), 32'h1);
                chk($sformatf("rr%0d_rsp_id", k), 32'(rsp_id), 32'(rr_grant(k - 3)));
                chk($sformatf("rr%0d_rsp_logsin", k), 32'(rsp_logsin), 32'(lut_fn(8'(rr_grant(k - 3)))));
            end else begin
                chk($sformatf("rr%0d_rsp_idle", k), 32'(rsp_valid), 32'h0);
            end
            after_edge();
        end
        @(negedge clk);
        chk("rr_drained", 32'(rsp_valid), 32'h0);
        after_edge();

        // Withdrawn request leaves no trace; pointer stays at the last real grant
        req_phase = 40'd0;
        req_valid = 4'b0011;
        @(negedge clk);
        chk("wd_grant0", 32'(req_ready), 32'h1);
        after_edge();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("wd_idle", 32'(req_ready), 32'h0);
        after_edge();
        req_valid = 4'b1110;
        @(negedge clk);
        chk("wd_next", 32'(req_ready), 32'h2);
        after_edge();
        req_valid = 4'b0000;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("wd_rsp_count", 32'(cnt), 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
